// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle CPU control FSM (fetch/decode/exec/mem/wb) with retired-instruction count.
// Optional handshake watchdog enabled by defining SEQ_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int TO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic [3:0]  op,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        imem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pcsrc,
  output logic        jump,
  output logic        alusrc,
  output logic        regdst,
  output logic        regwrite,
  output logic        memtoreg,
  output logic [3:0]  alucontrol,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        trap,
  output logic        timeout,
  output logic [2:0]  state,
  output logic [15:0] instret
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;
  state_t state_q, state_d;
  logic [15:0] instret_q, instret_d;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_legal;
  logic [3:0] alu_op;
  logic to_hit;
  always_comb begin
    is_r     = op <= 4'h6;
    is_addi  = op == 4'h8;
    is_lw    = op == 4'h9;
    is_sw    = op == 4'hA;
    is_beq   = op == 4'hB;
    is_j     = op == 4'hC;
    is_halt  = op == 4'hF;
    is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;
    alu_op   = (op == 4'h0 || is_addi || is_lw || is_sw) ? 4'b0010 :
               (op == 4'h1 || is_beq)                     ? 4'b0110 :
               (op == 4'h3)                               ? 4'b0001 :
               (op == 4'h4)                               ? 4'b0111 :
               (op == 4'h5)                               ? 4'b1000 :
               (op == 4'h6)                               ? 4'b1001 : 4'b0000;
  end
  // Controls are forced low while reset is held so nothing leaks before the first edge.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alucontrol = 4'b0000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_en    = imem_ack;
          state_d  = imem_ack ? DECODE : to_hit ? TRAP : FETCH;
        end
        DECODE: state_d = is_halt ? HALT : is_legal ? EXEC : TRAP;
        EXEC: begin
          alucontrol = alu_op;
          regdst     = is_r;
          alusrc     = is_addi | is_lw | is_sw;
          pcsrc      = is_beq & zero;
          jump       = is_j;
          pc_en      = is_beq | is_j;
          state_d    = (is_lw | is_sw) ? MEM : (is_beq | is_j) ? FETCH : WB;
        end
        MEM: begin
          alucontrol = alu_op;
          alusrc     = 1'b1;
          mem_req    = 1'b1;
          mem_we     = is_sw;
          pc_en      = is_sw & mem_ack;
          state_d    = mem_ack ? (is_sw ? FETCH : WB) : to_hit ? TRAP : MEM;
        end
        WB: begin
          alucontrol = alu_op;
          regdst     = is_r;
          alusrc     = is_addi | is_lw;
          memtoreg   = is_lw;
          regwrite   = 1'b1;
          pc_en      = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end
  assign instret_d = instret_q + {15'd0, pc_en};
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
`ifdef SEQ_TIMEOUT_EN
  localparam int CW = (TO_CYCLES > 255) ? $clog2(TO_CYCLES + 1) : 8;
  logic [CW-1:0] wait_q, wait_d;
  logic timeout_q, timeout_d;
  logic waiting;
  // Any state change (including entry to FETCH/MEM) restarts the wait count.
  always_comb begin
    waiting   = (state_q == FETCH && !imem_ack) || (state_q == MEM && !mem_ack);
    wait_d    = (state_d == state_q) ? wait_q + 1'b1 : '0;
    timeout_d = timeout_q | (waiting & to_hit);
  end
  assign to_hit  = wait_q == CW'(TO_CYCLES - 1);
  assign timeout = timeout_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign to_hit  = 1'b0 & (TO_CYCLES == 0);
  assign timeout = 1'b0;
`endif
  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = state_q == HALT;
  assign trap    = state_q == TRAP;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven per-opcode checks plus directed multi-cycle sequences.
module tb_cpu_sequencer;
  logic clk = 1'b0, reset = 1'b0, imem_ack = 1'b0, zero = 1'b0, mem_ack = 1'b0;
  logic [3:0] op = 4'h0;
  logic imem_req, ir_en, pc_en, pcsrc, jump, alusrc, regdst, regwrite, memtoreg;
  logic mem_req, mem_we, halted, trap, timeout;
  logic [3:0] alucontrol;
  logic [2:0] state;
  logic [15:0] instret;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.TO_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .op(op), .zero(zero), .mem_ack(mem_ack),
    .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en), .pcsrc(pcsrc), .jump(jump),
    .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
    .alucontrol(alucontrol), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .trap(trap), .timeout(timeout), .state(state), .instret(instret)
  );

  typedef struct {
    int op, z, cyc, fin, alu, rd, as, ps, jp, rw, we, m2r, inc;
  } vec_t;
  vec_t v[16];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, rw, we, m2r, pe, ie, mr, mq, alu, rd, as, ps, jp;
    int exp_st[5];
    //          op  z cyc fin alu     rd as ps jp rw we m2r inc
    v[0]  = '{'h0, 1, 4, 0, 'b0010, 1, 0, 0, 0, 1, 0, 0, 1};
    v[1]  = '{'h1, 0, 4, 0, 'b0110, 1, 0, 0, 0, 1, 0, 0, 1};
    v[2]  = '{'h2, 0, 4, 0, 'b0000, 1, 0, 0, 0, 1, 0, 0, 1};
    v[3]  = '{'h3, 0, 4, 0, 'b0001, 1, 0, 0, 0, 1, 0, 0, 1};
    v[4]  = '{'h4, 0, 4, 0, 'b0111, 1, 0, 0, 0, 1, 0, 0, 1};
    v[5]  = '{'h5, 0, 4, 0, 'b1000, 1, 0, 0, 0, 1, 0, 0, 1};
    v[6]  = '{'h6, 0, 4, 0, 'b1001, 1, 0, 0, 0, 1, 0, 0, 1};
    v[7]  = '{'h8, 0, 4, 0, 'b0010, 0, 1, 0, 0, 1, 0, 0, 1};
    v[8]  = '{'h9, 0, 5, 0, 'b0010, 0, 1, 0, 0, 1, 0, 1, 1};
    v[9]  = '{'hA, 0, 4, 0, 'b0010, 0, 1, 0, 0, 0, 1, 0, 1};
    v[10] = '{'hB, 1, 3, 0, 'b0110, 0, 0, 1, 0, 0, 0, 0, 1};
    v[11] = '{'hB, 0, 3, 0, 'b0110, 0, 0, 0, 0, 0, 0, 0, 1};
    v[12] = '{'hC, 0, 3, 0, 'b0000, 0, 0, 0, 1, 0, 0, 0, 1};
    v[13] = '{'hF, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[14] = '{'h7, 0, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[15] = '{'hD, 0, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_st = '{0, 1, 2, 4, 0};

    foreach (v[i]) begin
      op = 4'(v[i].op);
      zero = v[i].z[0];
      reset = 1'b0;
      imem_ack = 1'b1;
      mem_ack = 1'b1;
      cyc1;
      chk($sformatf("v%0d reset state", i), int'(state), 0);
      chk($sformatf("v%0d reset imem_req", i), int'(imem_req), 0);
      chk($sformatf("v%0d reset instret", i), int'(instret), 0);
      reset = 1'b1;
      #1;
      n = 0; rw = 0; we = 0; m2r = 0; pe = 0; ie = 0;
      alu = 0; rd = 0; as = 0; ps = 0; jp = 0;
      do begin
        n++;
        rw += int'(regwrite);
        we += int'(mem_we);
        m2r += int'(memtoreg);
        pe += int'(pc_en);
        ie += int'(ir_en);
        if (state == 3'd2) begin
          alu = int'(alucontrol); rd = int'(regdst); as = int'(alusrc);
          ps = int'(pcsrc); jp = int'(jump);
        end
        cyc1;
      end while (state != 3'd0 && state != 3'd5 && state != 3'd6 && n < 20);
      chk($sformatf("v%0d cycles", i), n, v[i].cyc);
      chk($sformatf("v%0d end state", i), int'(state), v[i].fin);
      chk($sformatf("v%0d alucontrol", i), alu, v[i].alu);
      chk($sformatf("v%0d regdst", i), rd, v[i].rd);
      chk($sformatf("v%0d alusrc", i), as, v[i].as);
      chk($sformatf("v%0d pcsrc", i), ps, v[i].ps);
      chk($sformatf("v%0d jump", i), jp, v[i].jp);
      chk($sformatf("v%0d regwrite cycles", i), rw, v[i].rw);
      chk($sformatf("v%0d mem_we cycles", i), we, v[i].we);
      chk($sformatf("v%0d memtoreg cycles", i), m2r, v[i].m2r);
      chk($sformatf("v%0d pc_en cycles", i), pe, v[i].inc);
      chk($sformatf("v%0d ir_en cycles", i), ie, 1);
      chk($sformatf("v%0d instret", i), int'(instret), v[i].inc);
      chk($sformatf("v%0d halted", i), int'(halted), int'(v[i].fin == 5));
      chk($sformatf("v%0d trap", i), int'(trap), int'(v[i].fin == 6));
      if (v[i].fin != 0) begin
        repeat (3) cyc1;
        chk($sformatf("v%0d absorbing state", i), int'(state), v[i].fin);
        chk($sformatf("v%0d absorbing imem_req", i), int'(imem_req), 0);
        chk($sformatf("v%0d absorbing instret", i), int'(instret), 0);
      end
    end

    // ADD cycle-by-cycle
    op = 4'h0; zero = 1'b0; reset = 1'b0; imem_ack = 1'b1; mem_ack = 1'b0;
    cyc1;
    reset = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("add c%0d state", c + 1), int'(state), exp_st[c]);
      chk($sformatf("add c%0d regwrite", c + 1), int'(regwrite), int'(c == 3));
      chk($sformatf("add c%0d pc_en", c + 1), int'(pc_en), int'(c == 3));
      if (c < 4) cyc1;
    end
    chk("add instret", int'(instret), 1);

    // LW with mem_ack delayed 3 cycles
    op = 4'h9; reset = 1'b0; imem_ack = 1'b1; mem_ack = 1'b0;
    cyc1;
    reset = 1'b1;
    #1;
    n = 0; mr = 0; mq = 0; we = 0; m2r = 0; rw = 0;
    do begin
      n++;
      if (state == 3'd3) begin
        mq++;
        mem_ack = (mq == 4);
        #1;
      end
      mr += int'(mem_req);
      we += int'(mem_we);
      if (state == 3'd4) begin
        m2r += int'(memtoreg);
        rw += int'(regwrite);
      end
      cyc1;
      mem_ack = 1'b0;
    end while (state != 3'd0 && n < 30);
    chk("lw cycles", n, 8);
    chk("lw mem_req cycles", mr, 4);
    chk("lw mem_we cycles", we, 0);
    chk("lw wb memtoreg", m2r, 1);
    chk("lw wb regwrite", rw, 1);
    chk("lw instret", int'(instret), 1);

    // J retires, then reset lands in the middle of an SW memory wait
    op = 4'hC; reset = 1'b0; imem_ack = 1'b1; mem_ack = 1'b0;
    cyc1;
    reset = 1'b1;
    repeat (3) cyc1;
    chk("j then fetch state", int'(state), 0);
    chk("j instret", int'(instret), 1);
    op = 4'hA;
    repeat (5) cyc1;
    chk("sw wait state", int'(state), 3);
    chk("sw wait mem_we", int'(mem_we), 1);
    chk("sw wait mem_req", int'(mem_req), 1);
    reset = 1'b0;
    cyc1;
    chk("rst sw state", int'(state), 0);
    chk("rst sw mem_req", int'(mem_req), 0);
    chk("rst sw mem_we", int'(mem_we), 0);
    chk("rst sw instret", int'(instret), 0);
    chk("rst sw imem_req", int'(imem_req), 0);
    cyc1;
    chk("rst held ir_en", int'(ir_en), 0);
    reset = 1'b1;
    #1;
    chk("first imem_req after reset", int'(imem_req), 1);

    // Stalled fetch: watchdog trips or waits forever depending on build
    reset = 1'b0; imem_ack = 1'b0;
    cyc1;
    chk("stall reset timeout", int'(timeout), 0);
    reset = 1'b1;
    #1;
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (state == 3'd0 && n < 20) begin
      n++;
      cyc1;
    end
    chk("timeout fetch cycles", n, 4);
    chk("timeout state", int'(state), 6);
    chk("timeout trap", int'(trap), 1);
    chk("timeout flag", int'(timeout), 1);
`else
    n = 0;
    repeat (1000) begin
      n += int'(state == 3'd0 && imem_req);
      cyc1;
    end
    chk("stall fetch cycles", n, 1000);
    chk("stall state", int'(state), 0);
    chk("stall timeout", int'(timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
